// File: rtl/arm_defs_pkg.sv
// Shared ARM definitions: ALU command codes, opcode/mode/condition encodings, flag indices,
// and the EX-stage control bundle.
package arm_defs_pkg;

    // EXE_CMD codes consumed by the ALU
    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    // Data-processing opcodes, instr[24:21]
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // Instruction class, instr[27:26]
    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    // Condition codes, instr[31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Bit positions inside {N,Z,C,V}
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef struct packed {
        logic [3:0] cmd;
        logic       valid;
        logic       wb;
        logic       mem_r;
        logic       mem_w;
        logic       b;
        logic       s;
        logic       imm;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_BUBBLE = '0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-field evaluator against {N,Z,C,V}.
module cond_check
    import arm_defs_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Map each condition code to its flag predicate
    always_comb begin
        pass = 1'b0;
        unique case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_ctrl_stage.sv
// ID->EX control stage: decodes the instruction into the ALU command bundle, applies the
// condition field (with flag bypass from the ALU) and owns the CPSR NZCV register.
module ex_ctrl_stage
    import arm_defs_pkg::*;
#(
    parameter logic [3:0] RESET_STATUS = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic        instr_valid,
    input  logic [31:0] instr_in,
    input  logic [3:0]  alu_status_in,
    output logic [3:0]  exe_cmd_out,
    output logic        valid_out,
    output logic        wb_en_out,
    output logic        mem_r_en_out,
    output logic        mem_w_en_out,
    output logic        b_out,
    output logic        s_out,
    output logic        imm_out,
    output logic        carry_out,
    output logic [3:0]  status_out
);

    ex_ctrl_t   ex_q, ex_d, dec;
    logic [3:0] cpsr_q, cpsr_d;
    logic [3:0] eff_flags;
    logic       cond_pass;
    logic [1:0] mode;
    logic [3:0] opcode;
    logic       unused_instr;

    assign mode         = instr_in[27:26];
    assign opcode       = instr_in[24:21];
    assign unused_instr = ^instr_in[19:0];

    // Flags from an S instruction still in EX are not in the CPSR yet; forward them
    assign eff_flags = (ex_q.valid && ex_q.s) ? alu_status_in : cpsr_q;

    cond_check u_cond_check (
        .cond  (instr_in[31:28]),
        .flags (eff_flags),
        .pass  (cond_pass)
    );

    // Decode the ID-stage instruction into a control bundle
    always_comb begin
        dec       = EX_BUBBLE;
        dec.valid = 1'b1;
        dec.imm   = instr_in[25];
        unique case (mode)
            MODE_DP: begin
                dec.s = instr_in[20];
                case (opcode)
                    OP_MOV: begin dec.cmd = EXE_MOV; dec.wb = 1'b1; end
                    OP_MVN: begin dec.cmd = EXE_MVN; dec.wb = 1'b1; end
                    OP_ADD: begin dec.cmd = EXE_ADD; dec.wb = 1'b1; end
                    OP_ADC: begin dec.cmd = EXE_ADC; dec.wb = 1'b1; end
                    OP_SUB: begin dec.cmd = EXE_SUB; dec.wb = 1'b1; end
                    OP_SBC: begin dec.cmd = EXE_SBC; dec.wb = 1'b1; end
                    OP_AND: begin dec.cmd = EXE_AND; dec.wb = 1'b1; end
                    OP_ORR: begin dec.cmd = EXE_ORR; dec.wb = 1'b1; end
                    OP_EOR: begin dec.cmd = EXE_EOR; dec.wb = 1'b1; end
                    // Compare/test only exist to set flags
                    OP_CMP: begin dec.cmd = EXE_SUB; dec.s = 1'b1; end
                    OP_TST: begin dec.cmd = EXE_AND; dec.s = 1'b1; end
                    default: dec.cmd = EXE_NOP;
                endcase
            end
            MODE_MEM: begin
                dec.cmd = EXE_ADD;
                if (instr_in[20]) begin
                    dec.mem_r = 1'b1;
                    dec.wb    = 1'b1;
                end else begin
                    dec.mem_w = 1'b1;
                end
            end
            MODE_BR: dec.b = 1'b1;
            default: dec.cmd = EXE_NOP;
        endcase
    end

    // Next-state for the EX register and CPSR
    always_comb begin
        if (flush) begin
            ex_d = EX_BUBBLE;
        end else if (freeze) begin
            ex_d = ex_q;
        end else if (instr_valid && cond_pass) begin
            ex_d = dec;
        end else begin
            ex_d = EX_BUBBLE;
        end
        // The EX instruction retires even when flushed behind it, so flush does not gate this
        cpsr_d = (!freeze && ex_q.valid && ex_q.s) ? alu_status_in : cpsr_q;
    end

    // EX pipeline register and CPSR with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q   <= EX_BUBBLE;
            cpsr_q <= RESET_STATUS;
        end else begin
            ex_q   <= ex_d;
            cpsr_q <= cpsr_d;
        end
    end

    assign exe_cmd_out  = ex_q.cmd;
    assign valid_out    = ex_q.valid;
    assign wb_en_out    = ex_q.wb;
    assign mem_r_en_out = ex_q.mem_r;
    assign mem_w_en_out = ex_q.mem_w;
    assign b_out        = ex_q.b;
    assign s_out        = ex_q.s;
    assign imm_out      = ex_q.imm;
    assign carry_out    = cpsr_q[FLAG_C];
    assign status_out   = cpsr_q;

endmodule

// File: doc/ex_ctrl_stage.md
Name: ex_ctrl_stage

Overview:
- ID→EX control stage that feeds the ALU: it decodes an ARM data-processing, memory or branch instruction into the 4-bit EXE_CMD code the ALU consumes.
- It evaluates the instruction's condition field against the CPSR flags and registers the resulting control bundle into the EX stage.
- It owns the CPSR NZCV register, loaded from the ALU's {N,Z,C,V} status when the EX-stage instruction has S set.
- It sits between the decode logic and the ALU. It is the producer of EXE_CMD and the consumer of ALU status.

Parameters:
- RESET_STATUS, 4'b0000, CPSR NZCV value after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  hazard stall: hold EX register and CPSR.
- flush  in  1  taken-branch flush: insert bubble into EX.
- instr_valid  in  1  instr_in carries a real instruction.
- instr_in  in  32  ID-stage instruction word.
- alu_status_in  in  4  {N,Z,C,V} from the ALU for the current EX instruction.
- exe_cmd_out  out  4  registered EXE_CMD to the ALU.
- valid_out  out  1  EX slot holds an executing instruction.
- wb_en_out  out  1  register write-back enable.
- mem_r_en_out  out  1  load.
- mem_w_en_out  out  1  store.
- b_out  out  1  branch taken in EX.
- s_out  out  1  EX instruction updates flags.
- imm_out  out  1  instr[25] (immediate operand).
- carry_out  out  1  CPSR C, driven to the ALU status input.
- status_out  out  4  CPSR {N,Z,C,V}.

Behaviour:
- Reset (rst=1 at the edge): every registered output is 0; CPSR = RESET_STATUS. Reset wins over freeze and flush.
- Latency: 1 cycle from instr_in to the *_out registers.
- Decode for mode = instr[27:26] = 00, opcode = instr[24:21] (opcode → EXE_CMD, wb):
  - 1101 MOV → 0001, wb=1
  - 1111 MVN → 1001, wb=1
  - 0100 ADD → 0010, wb=1
  - 0101 ADC → 0011, wb=1
  - 0010 SUB → 0100, wb=1
  - 0110 SBC → 0101, wb=1
  - 0000 AND → 0110, wb=1
  - 1100 ORR → 0111, wb=1
  - 0001 EOR → 1000, wb=1
  - 1010 CMP → 0100, wb=0
  - 1000 TST → 0110, wb=0
  - other opcodes → EXE_CMD 0000, wb=0, valid=1 (NOP)
  - s = instr[20]. CMP and TST force s=1.
- Decode for mode = 01 (memory):
  - EXE_CMD = 0010, s = 0.
  - instr[20]=1 → LDR: mem_r=1, wb=1.
  - instr[20]=0 → STR: mem_w=1.
- Decode for mode = 10 (branch): b=1, EXE_CMD = 0000, wb=0, s=0.
- Decode for mode = 11: NOP.
- Effective flags: if the EX slot has valid_out & s_out, use alu_status_in (bypass); otherwise use CPSR.
- Condition = instr[31:28], evaluated on the effective flags:
  - EQ Z; NE !Z
  - CS C; CC !C
  - MI N; PL !N
  - VS V; VC !V
  - HI C&!Z; LS !C|Z
  - GE N==V; LT N!=V
  - GT !Z&(N==V); LE Z|(N!=V)
  - AL 1; 1111 0
- Condition false, or instr_valid=0: the bubble is loaded, i.e. all *_out control = 0 and exe_cmd_out = 0.
- Next-state priority for the EX register:
  1. rst
  2. flush → bubble
  3. freeze → hold
  4. otherwise load the decoded bundle
- CPSR update: on an edge with rst=0 and freeze=0, if valid_out & s_out then CPSR ← alu_status_in.
  - The update is independent of flush, because the instruction in EX still retires.
  - Under freeze the CPSR holds. The ALU recomputes the frozen instruction with the unchanged carry, so ADC/SBC never see their own result.
- carry_out = CPSR[1] (registered value, not the bypass).
- imm_out holds instr[25], or 0 for a bubble.

Decomposition:
- Shared package arm_defs_pkg holds:
  - EXE_CMD codes (EXE_MOV…EXE_EOR, EXE_NOP).
  - ARM opcode and mode constants.
  - Condition codes.
  - Flag bit indices N=3, Z=2, C=1, V=0.
- One natural sub-module, cond_check: purely combinational, (cond[3:0], flags[3:0]) → pass.
- Decode and the pipeline register stay in ex_ctrl_stage.

Test Plan:
- Reset: assert rst with instr 0xE0910002 (ADDS) present → all outputs 0 and status_out=0. Release rst → next cycle exe_cmd_out=0010, wb=1, s=1.
- Flag bypass: SUBS r0,r0,r0 in EX with alu_status_in=0100, plus 0x01A01001 (MOVEQ) in ID.
  - Required next cycle: exe_cmd_out=0001, valid_out=1, status_out=0100.
  - Repeat with alu_status_in=0000 → bubble.
- CMP/TST: 0xE1500001 → exe_cmd_out=0100, wb=0, s=1. 0xE1100001 → exe_cmd_out=0110, wb=0, s=1.
- Memory and branch:
  - 0xE5910004 (LDR) → exe_cmd 0010, mem_r=1, wb=1.
  - 0xE5810004 (STR) → mem_w=1, wb=0.
  - 0xEA000003 (B) → b_out=1.
- Freeze then flush: ADCS held in EX under freeze for 3 cycles → outputs stable, CPSR unchanged, carry_out constant. Release → CPSR loads alu_status_in. Then assert flush together with a valid instr → bubble; an S instruction in EX still updates the CPSR.
- Never/invalid: cond=1111 or instr_valid=0 → bubble. Unknown opcode 0111 with AL → valid_out=1, EXE_CMD 0000, wb=0.
